// File: rtl/decode_issue_ctrl.sv
// Decode-stage controller: owns the IF/ID latch, issues to EX, inserts load-use bubbles, raises illegal-instruction traps.
// Optional performance counters are built when DECODE_PERF_CNT_EN is defined.
module decode_issue_ctrl #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned PERF_CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_illegal,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_ready,
  output logic        issue,
  input  logic        flush,
  output logic        trap_req,
  output logic [31:0] trap_pc,
  input  logic        trap_ack
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_issue_cnt,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {RUN, STALL, TRAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] stall_cnt;
  logic             hazard;
  logic             capture;

  // Load-use hazard against the load currently in EX; r0 never hazards.
  always_comb begin
    hazard = id_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
             ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  end

  always_comb begin
    issue    = (state == RUN) & id_valid & ~id_is_illegal & ~hazard & ex_ready & ~flush;
    if_ready = ~flush & (state == RUN) & (~id_valid | issue);
    capture  = if_valid & if_ready;
  end

  // State, stall counter, ID latch and trap registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      stall_cnt <= '0;
      id_valid  <= 1'b0;
      id_instr  <= 32'h0000_0000;
      id_pc     <= 32'h0000_0000;
      trap_req  <= 1'b0;
      trap_pc   <= 32'h0000_0000;
    end else if (flush) begin
      state     <= RUN;
      stall_cnt <= '0;
      id_valid  <= 1'b0;
      trap_req  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (capture) begin
            id_valid <= 1'b1;
            id_instr <= if_instr;
            id_pc    <= if_pc;
          end else if (issue) begin
            id_valid <= 1'b0;
          end
          // A hazarding illegal instruction stalls first and traps once the hazard clears.
          if (hazard) begin
            state     <= STALL;
            stall_cnt <= CNT_W'(LOAD_USE_BUBBLES - 1);
          end else if (id_valid & id_is_illegal) begin
            state    <= TRAP;
            trap_req <= 1'b1;
            trap_pc  <= id_pc;
            id_valid <= 1'b0;
          end
        end
        STALL: begin
          if (stall_cnt == '0) begin
            state <= RUN;
          end else begin
            stall_cnt <= stall_cnt - CNT_W'(1);
          end
        end
        TRAP: begin
          if (trap_ack) begin
            trap_req <= 1'b0;
            state    <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef DECODE_PERF_CNT_EN
  localparam logic [PERF_CNT_W-1:0] PERF_MAX = '1;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue && (perf_issue_cnt != PERF_MAX)) begin
        perf_issue_cnt <= perf_issue_cnt + PERF_CNT_W'(1);
      end
      if ((state == STALL) && (perf_stall_cnt != PERF_MAX)) begin
        perf_stall_cnt <= perf_stall_cnt + PERF_CNT_W'(1);
      end
    end
  end
`else
  logic unused_perf_w;
  assign unused_perf_w = 1'(PERF_CNT_W);
`endif

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Sequences the decode stage: owns the IF/ID pipeline latch that feeds the instruction decoder and next-PC logic.
- Issues decoded instructions to EX with a valid/ready handshake.
- Inserts load-use stall bubbles and converts illegal instructions into a trap request.
- Sits between fetch and the combinational decode block; the decoder's rs/rt/illegal outputs feed back into this controller.

Parameters:
- LOAD_USE_BUBBLES, 1, number of cycles issue is held after a load-use hazard is detected (1..15).
- PERF_CNT_W, 32, width of the performance counters (used only with DECODE_PERF_CNT_EN).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  fetched instruction word
- if_pc  in  32  PC of the fetched instruction
- if_ready  out  1  latch accepts a new instruction this cycle
- id_valid  out  1  ID latch holds a live instruction
- id_instr  out  32  latched instruction, to decoder
- id_pc  out  32  latched PC, to next-PC logic
- id_rs  in  5  source register rs from decoder
- id_rt  in  5  source register rt from decoder
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_is_illegal  in  1  decoder flags illegal opcode
- ex_valid  in  1  EX stage holds a live instruction
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_ready  in  1  EX accepts an issue this cycle
- issue  out  1  instruction transferred to EX this cycle
- flush  in  1  redirect from a later stage; kill the ID contents
- trap_req  out  1  illegal-instruction trap pending
- trap_pc  out  32  PC of the trapping instruction
- trap_ack  in  1  trap handler accepted the request

Behaviour:
- States: RUN, STALL, TRAP.
- Reset values:
  - state=RUN, stall counter=0
  - id_valid=0, id_instr=32'h0000_0000 (NOP), id_pc=0
  - trap_req=0, trap_pc=0
- hazard (combinational) = id_valid & ex_valid & ex_is_load & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- issue (combinational) = (state==RUN) & id_valid & !id_is_illegal & !hazard & ex_ready & !flush.
- if_ready (combinational) = !flush & (state==RUN) & (!id_valid | issue). Fetch-to-ID latency is 1 cycle.
- Capture: on if_valid & if_ready, the ID latch loads if_instr/if_pc and id_valid<=1.
  - On issue without capture, id_valid<=0.
  - Issue and capture in the same cycle give back-to-back throughput of 1 instruction/cycle.
- RUN -> STALL when id_valid & hazard & !flush. Counter loads LOAD_USE_BUBBLES-1.
- STALL:
  - issue=0 and if_ready=0; the latch holds.
  - The counter decrements each cycle. At 0, return to RUN, where the hazard is re-evaluated.
  - Total stall is exactly LOAD_USE_BUBBLES cycles per detection.
- RUN -> TRAP when id_valid & id_is_illegal & !hazard & !flush.
  - Next cycle: trap_req=1, trap_pc=id_pc, id_valid=0.
  - If the instruction is both illegal and hazarding, the hazard wins; it stalls first.
- TRAP:
  - if_ready=0, issue=0.
  - trap_req stays high until trap_ack is sampled high.
  - Then trap_req<=0 and state<=RUN with an empty latch. trap_pc holds its value until the next trap.
- flush has the highest priority after reset:
  - id_valid<=0, state<=RUN, counter<=0, trap_req<=0.
  - No capture or issue in the flush cycle.
- trap_ack outside TRAP is ignored.
- ex_rd==0 never causes a hazard.
- Reset mid-stall or mid-trap returns all state to reset values on the next edge.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- When defined, two extra outputs are present, perf_issue_cnt [PERF_CNT_W-1:0] and perf_stall_cnt [PERF_CNT_W-1:0]:
  - perf_issue_cnt increments on issue.
  - perf_stall_cnt increments on each cycle in STALL.
  - Both saturate at all-ones and clear on reset only.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Streaming: if_valid=1 with PCs 0x0,0x4,0x8, ex_ready=1, no hazards -> issue high on cycles 1,2,3; id_pc=0x0,0x4,0x8 in order.
- Load-use stall: EX holds a load with ex_rd=5, ID instruction has uses_rs=1, rs=5, LOAD_USE_BUBBLES=2 -> issue=0 and if_ready=0 for exactly 2 cycles, then issue once ex_valid drops.
- Backpressure: ex_ready=0 for 3 cycles with id_valid=1 -> id_instr/id_pc stable, if_ready=0, issue=0. Release -> issue in the same cycle ex_ready rises.
- Illegal trap: id_pc=0x40, id_is_illegal=1 -> trap_req=1 and trap_pc=0x40 next cycle, held for 4 cycles until trap_ack. Then RUN with id_valid=0 and if_ready=1.
- Flush during STALL and during TRAP -> next cycle id_valid=0, trap_req=0, state RUN. An if_valid in the flush cycle is not captured.
- Reset: assert reset in STALL with DECODE_PERF_CNT_EN -> all outputs at reset values, both perf counters 0. Saturation check with PERF_CNT_W=4: 20 issues -> perf_issue_cnt=15.
